// File: rtl/race_pkg.sv
// ============================================================================
//  Module   : race_pkg
//  Purpose  : Shared types and helpers for the race-logic "a before b" array.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package race_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      FIRE    = 3'd2,
      DONE    = 3'd3,
      BLOCKED = 3'd4
   } chan_state_t;

   // Counter must hold the value PULSE_WIDTH itself.
   function automatic int pulse_cnt_width(input int pulse_width);
      return $clog2(pulse_width + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/race_lt_chan.sv
// ============================================================================
//  Module   : race_lt_chan
//  Purpose  : One channel: edge detect, a-before-b FSM, pulse and timestamp.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module race_lt_chan
   import race_pkg::*;
#(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH       = 8,
   parameter int TIE_PASS          = 0
) (
   input  logic                         aclk,
   input  logic                         grst_n,
   input  logic                         rst,
   input  logic                         a,
   input  logic                         b,
   input  logic [GAMMA_CYCLE_WIDTH-1:0] gamma_time,
   output logic                         y,
   output logic                         y_valid,
   output logic [GAMMA_CYCLE_WIDTH-1:0] y_time
);

   localparam int                 c_CNT_W    = pulse_cnt_width(PULSE_WIDTH);
   localparam logic [c_CNT_W-1:0] c_PW       = c_CNT_W'(PULSE_WIDTH);
   localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
   localparam logic               c_TIE_PASS = (TIE_PASS != 0);

   chan_state_t                  r_state;
   logic                         r_prev_a;
   logic                         r_prev_b;
   logic [c_CNT_W-1:0]           r_cnt;
   logic                         r_y;
   logic                         r_valid;
   logic [GAMMA_CYCLE_WIDTH-1:0] r_time;

   logic w_a_rise;
   logic w_b_rise;

   assign w_a_rise = a & ~r_prev_a;
   assign w_b_rise = b & ~r_prev_b;

   always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
         r_state  <= IDLE;
         r_prev_a <= 1'b0;
         r_prev_b <= 1'b0;
         r_cnt    <= '0;
         r_y      <= 1'b0;
         r_valid  <= 1'b0;
         r_time   <= '0;
      end else begin
         r_prev_a <= a;
         r_prev_b <= b;
         // A new gamma cycle overrides everything, including a live pulse.
         if (rst) begin
            r_state <= ARMED;
            r_cnt   <= '0;
            r_y     <= 1'b0;
            r_valid <= 1'b0;
            r_time  <= '0;
         end else begin
            case (r_state)
               ARMED: begin
                  if (w_a_rise && (!w_b_rise || c_TIE_PASS)) begin
                     r_state <= FIRE;
                     r_y     <= 1'b1;
                     r_valid <= 1'b1;
                     r_cnt   <= c_ONE;
                     r_time  <= gamma_time;
                  end else if (w_b_rise) begin
                     r_state <= BLOCKED;
                  end
               end
               FIRE: begin
                  if (r_cnt == c_PW) begin
                     r_state <= DONE;
                     r_y     <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + c_ONE;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign y       = r_y;
   assign y_valid = r_valid;
   assign y_time  = r_time;

endmodule

`default_nettype wire

// File: rtl/race_lt_array.sv
// ============================================================================
//  Module   : race_lt_array
//  Purpose  : N_CH-channel gamma-synchronised "a strictly before b" array.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module race_lt_array
   import race_pkg::*;
#(
   parameter int N_CH              = 4,
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH       = 8,
   parameter int TIE_PASS          = 0
) (
   input  logic                              aclk,
   input  logic                              grst_n,
   input  logic                              rst,
   input  logic [N_CH-1:0]                   a,
   input  logic [N_CH-1:0]                   b,
   output logic [N_CH-1:0]                   y,
   output logic [N_CH-1:0]                   y_valid,
   output logic [N_CH*GAMMA_CYCLE_WIDTH-1:0] y_time,
   output logic [GAMMA_CYCLE_WIDTH-1:0]      gamma_time
);

   localparam logic [GAMMA_CYCLE_WIDTH-1:0] c_GAMMA_MAX = '1;
   localparam logic [GAMMA_CYCLE_WIDTH-1:0] c_GAMMA_ONE = GAMMA_CYCLE_WIDTH'(1);

   logic [GAMMA_CYCLE_WIDTH-1:0] r_gamma;

   // Saturates rather than wraps so late arrivals never alias early ones.
   always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
         r_gamma <= '0;
      end else if (rst) begin
         r_gamma <= '0;
      end else if (r_gamma != c_GAMMA_MAX) begin
         r_gamma <= r_gamma + c_GAMMA_ONE;
      end
   end

   assign gamma_time = r_gamma;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
         race_lt_chan #(
            .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
            .PULSE_WIDTH       (PULSE_WIDTH),
            .TIE_PASS          (TIE_PASS)
         ) u_chan (
            .aclk       (aclk),
            .grst_n     (grst_n),
            .rst        (rst),
            .a          (a[gi]),
            .b          (b[gi]),
            .gamma_time (r_gamma),
            .y          (y[gi]),
            .y_valid    (y_valid[gi]),
            .y_time     (y_time[gi*GAMMA_CYCLE_WIDTH +: GAMMA_CYCLE_WIDTH])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_race_lt_array.sv
// ============================================================================
//  Module   : tb_race_lt_array
//  Purpose  : Directed self-checking bench for race_lt_array (two configs).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_race_lt_array;

   logic        aclk;
   logic        grst_n;
   logic        rst;
   logic [3:0]  a,  b;
   logic [3:0]  a2, b2;
   logic [3:0]  y,  y_valid;
   logic [63:0] y_time;
   logic [15:0] gamma_time;
   logic [3:0]  y2, y_valid2;
   logic [15:0] y_time2;
   logic [3:0]  gamma_time2;

   int n_cmp;
   int n_err;

   race_lt_array #(
      .N_CH(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .TIE_PASS(0)
   ) dut (
      .aclk(aclk), .grst_n(grst_n), .rst(rst), .a(a), .b(b),
      .y(y), .y_valid(y_valid), .y_time(y_time), .gamma_time(gamma_time)
   );

   // Tie-pass, narrow-counter configuration.
   race_lt_array #(
      .N_CH(4), .GAMMA_CYCLE_WIDTH(4), .PULSE_WIDTH(8), .TIE_PASS(1)
   ) dut2 (
      .aclk(aclk), .grst_n(grst_n), .rst(rst), .a(a2), .b(b2),
      .y(y2), .y_valid(y_valid2), .y_time(y_time2), .gamma_time(gamma_time2)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_inputs;
      a = '0; b = '0; a2 = '0; b2 = '0;
      tick();
   endtask

   task automatic do_rst;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      grst_n = 1'b0; rst = 1'b0;
      a = '0; b = '0; a2 = '0; b2 = '0;
      #23;
      n_cmp++;
      if ({y, y_valid} !== 8'h00) begin
         n_err++; $display("FAIL reset_y_valid: got %h expected 00", {y, y_valid});
      end
      n_cmp++;
      if (y_time !== 64'h0) begin
         n_err++; $display("FAIL reset_y_time: got %h expected 0", y_time);
      end
      n_cmp++;
      if (gamma_time !== 16'h0 || gamma_time2 !== 4'h0) begin
         n_err++; $display("FAIL reset_gamma: got %h/%h expected 0/0", gamma_time, gamma_time2);
      end
      @(negedge aclk);
      grst_n = 1'b1;
      tick();
      a = 4'hF; a2 = 4'hF;
      ticks(3);
      n_cmp++;
      if ({y, y_valid, y2, y_valid2} !== 16'h0000) begin
         n_err++; $display("FAIL idle_ignores_a: got %h expected 0000", {y, y_valid, y2, y_valid2});
      end
   endtask

   task automatic test_a_before_b;
      int g;
      clear_inputs();
      do_rst();
      n_cmp++;
      if (gamma_time !== 16'd0 || y_valid !== 4'h0) begin
         n_err++; $display("FAIL rst_state: gamma=%0d valid=%h expected 0/0", gamma_time, y_valid);
      end
      ticks(5);
      n_cmp++;
      if (gamma_time !== 16'd5) begin
         n_err++; $display("FAIL gamma_count: got %0d expected 5", gamma_time);
      end
      a[0] = 1'b1;
      tick();
      g = 6;
      n_cmp++;
      if (y[0] !== 1'b1 || y_valid[0] !== 1'b1 || y_time[15:0] !== 16'd5) begin
         n_err++; $display("FAIL ab_fire: y=%b valid=%b time=%0d expected 1/1/5", y[0], y_valid[0], y_time[15:0]);
      end
      for (int i = 0; i < 10; i++) begin
         if (g == 9) b[0] = 1'b1;
         tick();
         g++;
         n_cmp++;
         if (y[0] !== ((i + 2) <= 8)) begin
            n_err++; $display("FAIL ab_pulse_%0d: y=%b expected %b", i, y[0], ((i + 2) <= 8));
         end
      end
      n_cmp++;
      if (y_valid[0] !== 1'b1 || y_time[15:0] !== 16'd5) begin
         n_err++; $display("FAIL ab_done_hold: valid=%b time=%0d expected 1/5", y_valid[0], y_time[15:0]);
      end
   endtask

   task automatic test_b_before_a;
      logic seen;
      clear_inputs();
      do_rst();
      ticks(3);
      b[1] = 1'b1;
      tick();
      a[1] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen = seen | y[1] | y_valid[1];
      end
      n_cmp++;
      if (seen !== 1'b0 || y_time[31:16] !== 16'd0) begin
         n_err++; $display("FAIL b_blocks_a: seen=%b time=%0d expected 0/0", seen, y_time[31:16]);
      end
   endtask

   task automatic test_tie;
      int hcnt;
      clear_inputs();
      do_rst();
      ticks(7);
      a[2] = 1'b1; b[2] = 1'b1; a2[2] = 1'b1; b2[2] = 1'b1;
      tick();
      n_cmp++;
      if (y[2] !== 1'b0 || y_valid[2] !== 1'b0) begin
         n_err++; $display("FAIL tie_inhibit: y=%b valid=%b expected 0/0", y[2], y_valid[2]);
      end
      n_cmp++;
      if (y2[2] !== 1'b1 || y_valid2[2] !== 1'b1 || y_time2[11:8] !== 4'd7) begin
         n_err++; $display("FAIL tie_pass: y=%b valid=%b time=%0d expected 1/1/7", y2[2], y_valid2[2], y_time2[11:8]);
      end
      hcnt = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (y2[2] === 1'b1) hcnt++;
      end
      n_cmp++;
      if (hcnt != 8) begin
         n_err++; $display("FAIL tie_pass_len: got %0d expected 8", hcnt);
      end
   endtask

   task automatic test_abort;
      clear_inputs();
      do_rst();
      ticks(2);
      a[3] = 1'b1;
      tick();
      ticks(2);
      n_cmp++;
      if (y[3] !== 1'b1 || y_time[63:48] !== 16'd2) begin
         n_err++; $display("FAIL abort_pre: y=%b time=%0d expected 1/2", y[3], y_time[63:48]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a[3] = 1'b0;
      n_cmp++;
      if (y[3] !== 1'b0 || y_valid[3] !== 1'b0 || y_time[63:48] !== 16'd0 || gamma_time !== 16'd0) begin
         n_err++; $display("FAIL abort_rst: y=%b valid=%b time=%0d gamma=%0d expected 0/0/0/0",
                           y[3], y_valid[3], y_time[63:48], gamma_time);
      end
      ticks(4);
      a[3] = 1'b1;
      tick();
      n_cmp++;
      if (y[3] !== 1'b1 || y_valid[3] !== 1'b1 || y_time[63:48] !== 16'd4) begin
         n_err++; $display("FAIL abort_refire: y=%b valid=%b time=%0d expected 1/1/4", y[3], y_valid[3], y_time[63:48]);
      end
   endtask

   task automatic test_saturation;
      int hcnt;
      clear_inputs();
      do_rst();
      ticks(20);
      n_cmp++;
      if (gamma_time2 !== 4'd15) begin
         n_err++; $display("FAIL sat_gamma: got %0d expected 15", gamma_time2);
      end
      a2[0] = 1'b1;
      tick();
      n_cmp++;
      if (y2[0] !== 1'b1 || y_time2[3:0] !== 4'd15 || gamma_time2 !== 4'd15) begin
         n_err++; $display("FAIL sat_fire: y=%b time=%0d gamma=%0d expected 1/15/15", y2[0], y_time2[3:0], gamma_time2);
      end
      hcnt = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (y2[0] === 1'b1) hcnt++;
      end
      n_cmp++;
      if (hcnt != 8 || y_valid2[0] !== 1'b1) begin
         n_err++; $display("FAIL sat_pulse: len=%0d valid=%b expected 8/1", hcnt, y_valid2[0]);
      end
   endtask

   task automatic test_grst_mid_pulse;
      clear_inputs();
      do_rst();
      tick();
      a[0] = 1'b1;
      tick();
      ticks(2);
      #2;
      grst_n = 1'b0;
      #1;
      n_cmp++;
      if ({y, y_valid} !== 8'h00 || y_time !== 64'h0 || gamma_time !== 16'h0) begin
         n_err++; $display("FAIL grst_async: y=%h valid=%h time=%h gamma=%h expected all 0",
                           y, y_valid, y_time, gamma_time);
      end
      @(negedge aclk);
      grst_n = 1'b1;
      a[0] = 1'b0;
      tick();
      tick();
      a[0] = 1'b1;
      ticks(2);
      n_cmp++;
      if (y[0] !== 1'b0 || y_valid[0] !== 1'b0) begin
         n_err++; $display("FAIL grst_idle: y=%b valid=%b expected 0/0", y[0], y_valid[0]);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_a_before_b();
      test_b_before_a();
      test_tie();
      test_abort();
      test_saturation();
      test_grst_mid_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/race_lt_array.md
# race_lt_array

Multi-channel, parametrised temporal "a strictly before b" primitive for the race-logic datapath. Each of N_CH channels passes its `a` spike as a fixed-width output pulse only if `a` rises before its inhibitor `b` within the current gamma cycle. Each channel also records the gamma-relative arrival time of the passed spike. It sits between the encoder front-end and the column/WTA stages, and replaces per-bit inhibit cells with one gamma-synchronised array.

## Interface
- N_CH, 4, number of independent channels
- GAMMA_CYCLE_WIDTH, 16, width of gamma-cycle time counter and captured timestamps
- PULSE_WIDTH, 8, output pulse length in aclk cycles; legal range ≥ 1
- TIE_PASS, 0, same-cycle a/b rise: 0 = inhibit, 1 = pass

- aclk  in  1  clock, all logic rising-edge
- grst_n  in  1  global reset, asynchronous, active-low
- rst  in  1  gamma-cycle start, synchronous, active-high, one-cycle strobe
- a  in  N_CH  per-channel input spike (level; rising edge is the event)
- b  in  N_CH  per-channel inhibitor spike (level; rising edge is the event)
- y  out  N_CH  per-channel output pulse
- y_valid  out  N_CH  channel fired in current gamma cycle (level)
- y_time  out  N_CH*GAMMA_CYCLE_WIDTH  captured arrival time; channel i occupies bits [i*GAMMA_CYCLE_WIDTH +: GAMMA_CYCLE_WIDTH]
- gamma_time  out  GAMMA_CYCLE_WIDTH  current gamma-cycle time

## Operation
- Shared gamma counter: cleared by rst, +1 per cycle otherwise, saturates at all-ones (no wrap).
- Edge detect: per-channel registers prev_a/prev_b sample a/b every cycle, including rst cycles. a_rise = a & ~prev_a; b_rise likewise.
- Per-channel FSM, states IDLE, ARMED, FIRE, DONE, BLOCKED.
  - IDLE: after grst_n. Inputs ignored. rst → ARMED.
  - ARMED: a_rise & ~b_rise → FIRE, capture y_time = gamma_time. b_rise & ~a_rise → BLOCKED. Both rise in the same cycle → FIRE if TIE_PASS, else BLOCKED. Neither → stay.
  - FIRE: y=1. Pulse counter counts PULSE_WIDTH cycles, then → DONE.
  - DONE / BLOCKED: y=0. Further edges ignored until rst.
- rst in any state → ARMED. This aborts an in-flight pulse: y low the next cycle. Clears y_valid and y_time. Edges in the rst cycle are ignored.
- A level already high at rst yields no edge. A held-high `a` does not fire unless it falls and rises again.
- y_valid = 1 in FIRE and DONE.
- Channels are fully independent. Only the gamma counter and rst are shared.

## Timing
- grst_n low: all state IDLE, counter 0, prev_* 0. Outputs y=0, y_valid=0, y_time=0, gamma_time=0. Deassertion is synchronised by the system; the block treats it as a clean edge.
- rst sampled at edge k: gamma_time=0 and FSM ARMED visible after edge k.
- a_rise sampled at edge t in ARMED: captured y_time equals gamma_time before edge t. y and y_valid are high after edge t. y stays high for exactly PULSE_WIDTH cycles, with its last high cycle after edge t+PULSE_WIDTH−1.
- b_rise at edge t blocks an a_rise at edge t+1 or later.
- Arrival at saturated counter: fires normally; y_time = all-ones.
- rst coincident with the final pulse cycle: rst wins, state ARMED.
- Latency a→y: 1 cycle (registered output).

## Structure
- Package race_pkg holds chan_state_t (IDLE, ARMED, FIRE, DONE, BLOCKED) and the pulse-counter width function clog2(PULSE_WIDTH+1).
- Sub-module race_lt_chan holds one channel: edge regs, FSM, pulse counter, timestamp register. Top instantiates N_CH copies in a generate loop and owns the gamma counter.

## Test plan
- grst_n low mid-pulse, a=1 → y, y_valid, y_time, gamma_time all 0 immediately; FSM IDLE. Later a_rise without rst → no y.
- rst at cycle 0; a[0] rises at gamma_time=5, b[0] rises at 9 (PULSE_WIDTH=8) → y[0] high 8 cycles, y_time[0]=5, y_valid[0]=1 until next rst.
- rst; b[1] rises at 3, a[1] rises at 4 → y[1] never asserts, y_valid[1]=0.
- a[2] and b[2] rise at same cycle, time 7 → TIE_PASS=0: no pulse; TIE_PASS=1: 8-cycle pulse, y_time[2]=7.
- a[3] fires at 2, rst at pulse cycle 3 → y[3] low next cycle, y_valid[3]=0, y_time[3]=0. A new a_rise at 4 fires again with y_time=4.
- GAMMA_CYCLE_WIDTH=4; a rises at cycle 20 after rst → gamma_time held at 15, y_time=15, pulse normal.
